// File: rtl/issue_scheduler_pkg.sv
// Shared constants and types for the issue scheduler and its multiplier tag pipe.
package issue_scheduler_pkg;

  localparam int unsigned WAYS     = 3;   // issue width, ALU count, CDB lanes
  localparam int unsigned PRF      = 64;  // physical registers
  localparam int unsigned ROB      = 16;  // ROB entries
  localparam int unsigned MULT_LAT = 4;   // grant-to-CDB multiplier latency, >= 2

  localparam int unsigned TAG_W = $clog2(PRF);
  localparam int unsigned ROB_W = $clog2(ROB);
  localparam int unsigned SRC_W = $clog2(WAYS + 1);
  localparam int unsigned INF_W = $clog2(MULT_LAT + 1);

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] prf_idx;
    logic [ROB_W-1:0] rob_idx;
  } issue_tag_t;

  // ALU k drives source code k; the multiplier sits just past the last ALU.
  typedef enum logic [SRC_W-1:0] {
    SRC_ALU0 = '0,
    SRC_MULT = SRC_W'(WAYS)
  } cdb_src_e;

endpackage

// File: rtl/issue_scheduler_mult_tag_pipe.sv
// Multiplier tag shift register: carries {valid, prf, rob} alongside the multiplier datapath.
module issue_scheduler_mult_tag_pipe
  import issue_scheduler_pkg::*;
(
  input  logic             clock,
  input  logic             clear,
  input  issue_tag_t       in_tag,
  output issue_tag_t       tail,
  output logic             due_next,
  output logic [INF_W-1:0] count
);

  issue_tag_t stage_q [MULT_LAT];

  // Shift one stage per cycle; clear squashes every stage
  always_ff @(posedge clock) begin
    if (clear) begin
      for (int i = 0; i < MULT_LAT; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= in_tag;
      for (int i = 1; i < MULT_LAT; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign tail     = stage_q[MULT_LAT-1];
  // Stage that will be at the tail (and on the CDB) next cycle
  assign due_next = stage_q[MULT_LAT-2].valid;

  // Occupancy: number of valid stages
  always_comb begin
    count = '0;
    for (int i = 0; i < MULT_LAT; i++) count = count + INF_W'(stage_q[i].valid);
  end

endmodule

// File: rtl/issue_scheduler.sv
// Issue scheduler: grants ready RS slots to ALUs and the multiplier, and packs CDB lanes.
module issue_scheduler
  import issue_scheduler_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic [WAYS-1:0]       req_valid,
  input  logic [WAYS-1:0]       req_is_mult,
  input  logic [WAYS*TAG_W-1:0] req_dest_prf,
  input  logic [WAYS*ROB_W-1:0] req_rob_idx,
  output logic [WAYS-1:0]       gnt,
  output logic [WAYS-1:0]       cdb_valid,
  output logic [WAYS*TAG_W-1:0] cdb_prf_idx,
  output logic [WAYS*ROB_W-1:0] cdb_rob_idx,
  output logic [WAYS*SRC_W-1:0] cdb_src,
  output logic [INF_W-1:0]      mult_inflight
);

  issue_tag_t alu_q [WAYS];
  issue_tag_t alu_d [WAYS];
  issue_tag_t mul_in;
  issue_tag_t mul_tail;
  logic       mult_due_next;
  logic       mul_taken;
  int         alu_budget;
  int         alu_cnt;
  int         lane;
  logic       lane_overflow;

  issue_scheduler_mult_tag_pipe u_mult_pipe (
    .clock    (clock),
    .clear    (reset | flush),
    .in_tag   (mul_in),
    .tail     (mul_tail),
    .due_next (mult_due_next),
    .count    (mult_inflight)
  );

  // Oldest-first grant scan; a multiplier landing next cycle takes one ALU lane away
  always_comb begin
    gnt        = '0;
    mul_in     = '0;
    mul_taken  = 1'b0;
    alu_cnt    = 0;
    alu_budget = int'(WAYS) - int'(mult_due_next);
    for (int k = 0; k < WAYS; k++) alu_d[k] = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (req_valid[i] && !reset && !flush) begin
        if (req_is_mult[i]) begin
          if (!mul_taken) begin
            gnt[i]         = 1'b1;
            mul_taken      = 1'b1;
            mul_in.valid   = 1'b1;
            mul_in.prf_idx = req_dest_prf[i*TAG_W +: TAG_W];
            mul_in.rob_idx = req_rob_idx[i*ROB_W +: ROB_W];
          end
        end else if (alu_cnt < alu_budget) begin
          gnt[i] = 1'b1;
          for (int j = 0; j < WAYS; j++) begin
            if (j == alu_cnt) begin
              alu_d[j].valid   = 1'b1;
              alu_d[j].prf_idx = req_dest_prf[i*TAG_W +: TAG_W];
              alu_d[j].rob_idx = req_rob_idx[i*ROB_W +: ROB_W];
            end
          end
          alu_cnt++;
        end
      end
    end
  end

  // ALU result stage: granted ops land here in grant order, one cycle before the CDB
  always_ff @(posedge clock) begin
    for (int k = 0; k < WAYS; k++) alu_q[k] <= (reset || flush) ? '0 : alu_d[k];
  end

  // CDB packing: multiplier tail owns lane 0, valid ALU results follow in k order
  always_comb begin
    cdb_valid     = '0;
    cdb_prf_idx   = '0;
    cdb_rob_idx   = '0;
    cdb_src       = '0;
    lane          = 0;
    lane_overflow = 1'b0;
    if (mul_tail.valid) begin
      cdb_valid[0]           = 1'b1;
      cdb_prf_idx[0 +: TAG_W] = mul_tail.prf_idx;
      cdb_rob_idx[0 +: ROB_W] = mul_tail.rob_idx;
      cdb_src[0 +: SRC_W]     = SRC_MULT;
      lane                    = 1;
    end
    for (int k = 0; k < WAYS; k++) begin
      if (alu_q[k].valid) begin
        if (lane >= int'(WAYS)) lane_overflow = 1'b1;
        for (int l = 0; l < WAYS; l++) begin
          if (l == lane) begin
            cdb_valid[l]               = 1'b1;
            cdb_prf_idx[l*TAG_W +: TAG_W] = alu_q[k].prf_idx;
            cdb_rob_idx[l*ROB_W +: ROB_W] = alu_q[k].rob_idx;
            cdb_src[l*SRC_W +: SRC_W]     = SRC_W'(k);
          end
        end
        lane++;
      end
    end
  end

  // The ALU budget must keep completions within WAYS lanes
  a_no_lane_overflow: assert property (@(posedge clock) disable iff (reset) !lane_overflow)
    else $error("issue_scheduler: CDB lane overflow");

endmodule

// File: tb/tb_issue_scheduler.sv
// Table-driven bench for issue_scheduler with a CDB scoreboard keyed by due cycle.
module tb_issue_scheduler;
  import issue_scheduler_pkg::*;

  logic                  clock = 1'b0;
  logic                  reset;
  logic                  flush;
  logic [WAYS-1:0]       req_valid;
  logic [WAYS-1:0]       req_is_mult;
  logic [WAYS*TAG_W-1:0] req_dest_prf;
  logic [WAYS*ROB_W-1:0] req_rob_idx;
  logic [WAYS-1:0]       gnt;
  logic [WAYS-1:0]       cdb_valid;
  logic [WAYS*TAG_W-1:0] cdb_prf_idx;
  logic [WAYS*ROB_W-1:0] cdb_rob_idx;
  logic [WAYS*SRC_W-1:0] cdb_src;
  logic [INF_W-1:0]      mult_inflight;

  always #5 clock = ~clock;

  issue_scheduler dut (
    .clock         (clock),
    .reset         (reset),
    .flush         (flush),
    .req_valid     (req_valid),
    .req_is_mult   (req_is_mult),
    .req_dest_prf  (req_dest_prf),
    .req_rob_idx   (req_rob_idx),
    .gnt           (gnt),
    .cdb_valid     (cdb_valid),
    .cdb_prf_idx   (cdb_prf_idx),
    .cdb_rob_idx   (cdb_rob_idx),
    .cdb_src       (cdb_src),
    .mult_inflight (mult_inflight)
  );

  typedef struct {
    string                 name;
    logic                  rst;
    logic                  fl;
    logic [WAYS-1:0]       v;
    logic [WAYS-1:0]       m;
    logic [WAYS*TAG_W-1:0] dest;
    logic [WAYS*ROB_W-1:0] rob;
    logic [WAYS-1:0]       exp_gnt;
    int                    exp_inf;  // -1: not checked
  } vec_t;

  typedef struct {
    int               due;
    logic             is_mult;
    logic [TAG_W-1:0] prf;
    logic [ROB_W-1:0] rob;
    int               src;
  } sb_t;

  sb_t  sb_q[$];
  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  bit   cdb_known = 1'b0;

  function automatic vec_t mk(string n, logic rs, logic fl, logic [WAYS-1:0] v,
                              logic [WAYS-1:0] m, int d0, int d1, int d2, int r0, int r1,
                              int r2, logic [WAYS-1:0] eg, int inf);
    vec_t t;
    t.name    = n;
    t.rst     = rs;
    t.fl      = fl;
    t.v       = v;
    t.m       = m;
    t.dest    = {TAG_W'(d2), TAG_W'(d1), TAG_W'(d0)};
    t.rob     = {ROB_W'(r2), ROB_W'(r1), ROB_W'(r0)};
    t.exp_gnt = eg;
    t.exp_inf = inf;
    return t;
  endfunction

  // Compare registered outputs against scoreboard entries due this cycle
  task automatic check_regs(input string name, input int exp_inf);
    logic [WAYS-1:0]       ev;
    logic [WAYS*TAG_W-1:0] ep;
    logic [WAYS*ROB_W-1:0] er;
    logic [WAYS*SRC_W-1:0] es;
    int                    ln;
    ev = '0; ep = '0; er = '0; es = '0; ln = 0;
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < sb_q.size(); i++) begin
        if (sb_q[i].due == cyc && (sb_q[i].is_mult == (pass == 0)) && ln < int'(WAYS)) begin
          ev = ev | (WAYS'(1) << ln);
          ep = ep | ((WAYS*TAG_W)'(sb_q[i].prf) << (ln*TAG_W));
          er = er | ((WAYS*ROB_W)'(sb_q[i].rob) << (ln*ROB_W));
          es = es | ((WAYS*SRC_W)'(sb_q[i].src) << (ln*SRC_W));
          ln++;
        end
      end
    end
    for (int i = sb_q.size() - 1; i >= 0; i--) if (sb_q[i].due <= cyc) sb_q.delete(i);
    if (cdb_known) begin
      n_cmp++;
      if ({cdb_valid, cdb_prf_idx, cdb_rob_idx, cdb_src} !== {ev, ep, er, es}) begin
        n_fail++;
        $display("FAIL %s cdb@%0d: got v=%b prf=%h rob=%h src=%h, want v=%b prf=%h rob=%h src=%h",
                 name, cyc, cdb_valid, cdb_prf_idx, cdb_rob_idx, cdb_src, ev, ep, er, es);
      end
    end
    if (exp_inf >= 0) begin
      n_cmp++;
      if (mult_inflight !== INF_W'(exp_inf)) begin
        n_fail++;
        $display("FAIL %s mult_inflight@%0d: got %0d want %0d", name, cyc, mult_inflight, exp_inf);
      end
    end
  endtask

  // One cycle: check registers, drive request, check gnt, push expected completions
  task automatic apply(input vec_t t);
    int alu_k;
    check_regs(t.name, t.exp_inf);
    reset = t.rst;
    flush = t.fl;
    if (t.rst) begin
      req_valid    = WAYS'($urandom);
      req_is_mult  = WAYS'($urandom);
      req_dest_prf = (WAYS*TAG_W)'($urandom);
      req_rob_idx  = (WAYS*ROB_W)'($urandom);
    end else begin
      req_valid    = t.v;
      req_is_mult  = t.m;
      req_dest_prf = t.dest;
      req_rob_idx  = t.rob;
    end
    #1;
    n_cmp++;
    if (gnt !== t.exp_gnt) begin
      n_fail++;
      $display("FAIL %s gnt@%0d: got %b want %b", t.name, cyc, gnt, t.exp_gnt);
    end
    alu_k = 0;
    for (int i = 0; i < WAYS; i++) begin
      if (t.exp_gnt[i]) begin
        if (t.m[i]) begin
          sb_q.push_back('{due: cyc + int'(MULT_LAT), is_mult: 1'b1,
                           prf: t.dest[i*TAG_W +: TAG_W], rob: t.rob[i*ROB_W +: ROB_W],
                           src: int'(WAYS)});
        end else begin
          sb_q.push_back('{due: cyc + 1, is_mult: 1'b0, prf: t.dest[i*TAG_W +: TAG_W],
                           rob: t.rob[i*ROB_W +: ROB_W], src: alu_k});
          alu_k++;
        end
      end
    end
    if (t.rst || t.fl) sb_q.delete();
    @(posedge clock);
    #1;
    cyc++;
    cdb_known = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; flush = 1'b0;
    req_valid = '0; req_is_mult = '0; req_dest_prf = '0; req_rob_idx = '0;

    //           name        rs fl v       m       dest        rob         gnt     inf
    tbl.push_back(mk("reset0",   1, 0, 3'b000, 3'b000,  0,  0,  0,  0,  0,  0, 3'b000, -1));
    tbl.push_back(mk("reset1",   1, 0, 3'b000, 3'b000,  0,  0,  0,  0,  0,  0, 3'b000,  0));
    tbl.push_back(mk("alu3",     0, 0, 3'b111, 3'b000,  5,  6,  7,  1,  2,  3, 3'b111,  0));
    tbl.push_back(mk("mixed",    0, 0, 3'b111, 3'b011,  9, 10, 11,  4,  5,  6, 3'b101,  0));
    tbl.push_back(mk("retry",    0, 0, 3'b001, 3'b001, 10,  0,  0,  5,  0,  0, 3'b001,  1));
    tbl.push_back(mk("alu101",   0, 0, 3'b101, 3'b000,  4,  0,  8,  7,  0,  8, 3'b101,  2));
    tbl.push_back(mk("budget",   0, 0, 3'b111, 3'b000, 20, 21, 22,  9, 10, 11, 3'b011,  2));
    tbl.push_back(mk("idle1",    0, 0, 3'b000, 3'b000,  0,  0,  0,  0,  0,  0, 3'b000,  2));
    tbl.push_back(mk("idle2",    0, 0, 3'b000, 3'b000,  0,  0,  0,  0,  0,  0, 3'b000,  1));
    tbl.push_back(mk("allm",     0, 0, 3'b111, 3'b111, 30, 31, 32, 12, 13, 14, 3'b001,  0));
    tbl.push_back(mk("allm_r1",  0, 0, 3'b011, 3'b011, 31, 32,  0, 13, 14,  0, 3'b001,  1));
    tbl.push_back(mk("allm_r2",  0, 0, 3'b001, 3'b001, 32,  0,  0, 14,  0,  0, 3'b001,  2));
    tbl.push_back(mk("alu_bud",  0, 0, 3'b111, 3'b000, 40, 41, 42,  1,  2,  3, 3'b011,  3));
    tbl.push_back(mk("mix_bud",  0, 0, 3'b111, 3'b100, 43, 44, 45,  4,  5,  6, 3'b111,  3));
    tbl.push_back(mk("alu_bud2", 0, 0, 3'b111, 3'b000, 50, 51, 52,  7,  8,  9, 3'b011,  3));
    tbl.push_back(mk("alu_full", 0, 0, 3'b111, 3'b000, 53, 54, 55, 10, 11, 12, 3'b111,  2));
    tbl.push_back(mk("idle3",    0, 0, 3'b000, 3'b000,  0,  0,  0,  0,  0,  0, 3'b000,  1));
    tbl.push_back(mk("idle4",    0, 0, 3'b000, 3'b000,  0,  0,  0,  0,  0,  0, 3'b000,  1));
    tbl.push_back(mk("idle5",    0, 0, 3'b000, 3'b000,  0,  0,  0,  0,  0,  0, 3'b000,  0));
    foreach (tbl[i]) apply(tbl[i]);

    // Flush with two mults in flight and an ALU result on the CDB in the flush cycle
    apply(mk("fl_m0",   0, 0, 3'b001, 3'b001, 60,  0,  0,  1,  0,  0, 3'b001, 0));
    apply(mk("fl_m1",   0, 0, 3'b011, 3'b001, 61, 62,  0,  2,  3,  0, 3'b011, 1));
    apply(mk("fl_cyc",  1'b0, 1'b1, 3'b111, 3'b001, 63, 0, 0, 4, 0, 0, 3'b000, 2));
    for (int i = 0; i < 5; i++)
      apply(mk("fl_after", 0, 0, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 0));

    // Reset together with flush mid-operation
    apply(mk("rs_pre",  0, 0, 3'b111, 3'b100, 70, 71, 72,  1,  2,  3, 3'b111, 0));
    apply(mk("rs_cyc",  1, 1, 3'b111, 3'b000,  0,  0,  0,  0,  0,  0, 3'b000, 1));
    for (int i = 0; i < 5; i++)
      apply(mk("rs_after", 0, 0, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/issue_scheduler.md
# issue_scheduler

Issue-stage scheduler between the reservation station and the functional units. It grants up to WAYS ready instructions per cycle to WAYS single-cycle ALUs and one pipelined multiplier. It reserves CDB lanes so that completions never exceed WAYS per cycle, and drives the per-lane CDB valid/tag/source-select that the RS, map table and ROB snoop.

## Interface
Parameters:
- WAYS, 3: issue width, ALU count and CDB lane count.
- PRF, 64: physical registers; tag width $clog2(PRF).
- ROB, 16: ROB entries; index width $clog2(ROB).
- MULT_LAT, 4: multiplier latency in cycles, grant to CDB; must be ≥2.

Ports:
- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- flush  in  1  squash; synchronous, clears all in-flight work.
- req_valid  in  WAYS  ready instruction offered on slot i; slot 0 is oldest.
- req_is_mult  in  WAYS  slot i needs the multiplier; otherwise it needs an ALU.
- req_dest_prf  in  WAYS×$clog2(PRF)  destination tag per slot.
- req_rob_idx  in  WAYS×$clog2(ROB)  ROB index per slot.
- gnt  out  WAYS  slot i issued this cycle; combinational from req and state.
- cdb_valid  out  WAYS  lane valid; lanes are packed from lane 0.
- cdb_prf_idx  out  WAYS×$clog2(PRF)  broadcast tag per lane.
- cdb_rob_idx  out  WAYS×$clog2(ROB)  completing ROB index per lane.
- cdb_src  out  WAYS×$clog2(WAYS+1)  data source per lane: 0..WAYS-1 = ALU k, WAYS = multiplier.
- mult_inflight  out  $clog2(MULT_LAT+1)  number of valid multiplier pipeline stages.

## Operation
- State: the ALU stage alu_q[WAYS] holds {valid, prf, rob}. The multiplier tag pipe mul_q[0..MULT_LAT-1] holds {valid, prf, rob}.
- mult_due_next = mul_q[MULT_LAT-2].valid, i.e. this stage reaches the tail next cycle.
- ALU budget = WAYS − mult_due_next.
- Grant scan runs over slots 0..WAYS-1 in order:
  - A mult request is granted if no mult has yet been granted this cycle.
  - An ALU request is granted if ALU grants so far are below the budget.
  - An ungranted slot does not block younger slots.
- gnt is forced to 0 when reset or flush is high.
- At the edge, granted ALU ops are written into alu_q in grant order (k = 0,1,…). Unused alu_q entries are cleared.
- At the edge, the granted mult is written into mul_q[0]; mul_q shifts by one every cycle.
- CDB packing is combinational from the registers:
  - If mul_q[MULT_LAT-1].valid, it occupies lane 0 with src = WAYS.
  - Valid alu_q entries fill the following lanes in k order, with src = k.
  - Unused lanes have valid, tags and src all 0.
- The budget rule guarantees at most WAYS lanes are needed. An overflow is a design error and is asserted in simulation.
- mult_inflight = popcount(mul_q valids).
- flush: at the edge, all alu_q and mul_q valids are cleared; requests in the flush cycle are not granted. reset has the same effect and overrides flush.

## Timing
- Reset values: gnt 0, cdb_valid 0, cdb_prf_idx 0, cdb_rob_idx 0, cdb_src 0, mult_inflight 0.
- ALU: granted in cycle t → on the CDB in cycle t+1.
- Multiplier: granted in cycle t → on the CDB in cycle t+MULT_LAT.
- Multiplier throughput is 1 per cycle; back-to-back mult grants are legal.
- The RS frees an entry on gnt at the same edge. gnt must not depend on CDB outputs of the same cycle (no comb loop).
- A flush in cycle t: no CDB output from pre-flush work from cycle t+1 on. Outputs during cycle t itself still reflect pre-flush state.
- Reset asserted mid-operation has the same effect as flush. reset and flush together behave as reset.
- All-mult requests: only the oldest is granted, and the others retry next cycle.

## Structure
- Shared package:
  - constants WAYS, PRF, ROB, MULT_LAT;
  - typedef issue_tag_t {valid, prf_idx, rob_idx};
  - typedef enum for cdb_src encoding, with SRC_MULT = WAYS.
- Sub-module mult_tag_pipe: a MULT_LAT-deep issue_tag_t shift register with a sync clear. It outputs the tail, the due-next valid and the occupancy count.
- Grant scan and lane packing live in the top as always_comb loops.

## Test plan
- Reset held 2 cycles with random req → gnt 000, cdb_valid 000, mult_inflight 0.
- ALU reqs 111 with dest 5,6,7 and rob 1,2,3 at cycle t → gnt 111. At t+1: cdb_valid 111, prf 5,6,7, rob 1,2,3, src 0,1,2.
- req 111 with is_mult 011, dest 9,10,11 → gnt 101. Slot 1 retried at t+1 → gnt. At t+4, lane 0: prf 9, src 3.
- Mult granted at t; three ALU reqs at t+3 → gnt 011. At t+4: lane 0 mult (src 3), lanes 1–2 ALU prf of slots 0–1.
- Two mults in flight plus flush at cycle t → gnt 000 in t. mult_inflight 0 at t+1, and no mult lane ever appears.
- ALU req 101 with dest 4, 8 → gnt 101. Next cycle cdb_valid 011, prf 4,8, src 0,1.
